// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear and per-channel hardware blink
// driven by a shared programmable half-period prescaler.
module led_pio_blink #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRESCALE_WIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [PRESCALE_WIDTH-1:0] RESET_PERIOD = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [WIDTH-1:0]    out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK    = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;

  logic [WIDTH-1:0]          data_q, data_n;
  logic [WIDTH-1:0]          blink_q, blink_n;
  logic [PRESCALE_WIDTH-1:0] period_q, period_n;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_n;
  logic                      phase_q, phase_n;
  logic [WIDTH-1:0]          out_n;
  logic                      wr;
  logic [WIDTH-1:0]          wd;

  // Upper writedata bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, writedata};

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  // Register file and prescaler next-state; a PERIOD write restarts the phase high.
  always_comb begin
    data_n   = data_q;
    blink_n  = blink_q;
    period_n = period_q;
    cnt_n    = cnt_q;
    phase_n  = phase_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_n   = wd;
        ADDR_BLINK:    blink_n  = wd;
        ADDR_PERIOD:   period_n = writedata[PRESCALE_WIDTH-1:0];
        ADDR_OUTSET:   data_n   = data_q | wd;
        ADDR_OUTCLEAR: data_n   = data_q & ~wd;
        default:       ;
      endcase
    end
    if (wr && address == ADDR_PERIOD) begin
      cnt_n   = '0;
      phase_n = 1'b1;
    end else if (period_q == '0) begin
      cnt_n   = '0;
      phase_n = 1'b1;
    end else if (cnt_q == period_q - PRESCALE_WIDTH'(1)) begin
      cnt_n   = '0;
      phase_n = ~phase_q;
    end else begin
      cnt_n   = cnt_q + PRESCALE_WIDTH'(1);
    end
    out_n = data_n & ~(blink_n & {WIDTH{~phase_n}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= RESET_PERIOD;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_port <= RESET_VALUE;
    end else begin
      data_q   <= data_n;
      blink_q  <= blink_n;
      period_q <= period_n;
      cnt_q    <= cnt_n;
      phase_q  <= phase_n;
      out_port <= out_n;
    end
  end

  // Zero-latency read of pre-write register state.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_BLINK:  readdata = 32'(blink_q);
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_OUTSET: readdata = 32'(out_port);
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed plus randomized bench for led_pio_blink against a time-based reference model.
module tb_led_pio_blink;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 24;
  localparam logic [W-1:0]  RV = 8'hA5;
  localparam logic [PW-1:0] RP = '0;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int compared = 0;
  int mismatched = 0;

  // Model state: registers plus the edge index at which the blink phase last restarted.
  logic [W-1:0]  m_data, m_blink, m_out;
  logic [PW-1:0] m_period;
  longint        edge_no = 0;
  longint        t0 = 0;
  bit            known = 0;

  led_pio_blink #(.WIDTH(W), .PRESCALE_WIDTH(PW), .RESET_VALUE(RV), .RESET_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_blink};
      3'd2: return {8'd0, m_period};
      3'd3: return {24'd0, m_out};
      default: return 32'd0;
    endcase
  endfunction

  // Phase is high for the first PERIOD edges after a restart, low for the next PERIOD, and so on.
  function automatic bit model_phase();
    if (m_period == '0) return 1'b1;
    return (((edge_no - t0) / longint'(m_period)) % 2) == 0;
  endfunction

  task automatic model_edge(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [31:0] d);
    edge_no++;
    if (rst) begin
      m_data = RV; m_blink = '0; m_period = RP; t0 = edge_no;
    end else if (cs && !wn) begin
      case (a)
        3'd0: m_data = d[W-1:0];
        3'd1: m_blink = d[W-1:0];
        3'd2: begin m_period = d[PW-1:0]; t0 = edge_no; end
        3'd3: m_data = m_data | d[W-1:0];
        3'd4: m_data = m_data & ~d[W-1:0];
        default: ;
      endcase
    end
    m_out = m_data & ~(m_blink & {W{~model_phase()}});
  endtask

  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] d, input string tag);
    logic [31:0] er;
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
    #1;
    if (known) begin
      er = exp_read(a);
      compared++;
      assert (readdata === er) else begin
        mismatched++;
        $error("FAIL %s readdata@%0d observed=%h expected=%h", tag, a, readdata, er);
      end
    end
    @(posedge clk);
    model_edge(rst, cs, wn, a, d);
    known = 1;
    @(negedge clk);
    compared++;
    assert (out_port === m_out) else begin
      mismatched++;
      $error("FAIL %s out_port observed=%h expected=%h", tag, out_port, m_out);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input string tag);
    step(1'b0, 1'b1, 1'b0, a, d, tag);
  endtask

  task automatic rd_reg(input logic [2:0] a, input string tag);
    step(1'b0, 1'b1, 1'b1, a, 32'd0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 3'(i), 32'hDEAD_BEEF, tag);
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "reset");
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "reset");
    compared++;
    assert (out_port === 8'hA5) else begin
      mismatched++;
      $error("FAIL reset_const out_port observed=%h expected=%h", out_port, 8'hA5);
    end
    for (int a = 0; a < 4; a++) rd_reg(3'(a), "reset_read");

    wr_reg(3'd0, 32'h0000_000F, "data_wr");
    compared++;
    assert (out_port === 8'h0F) else begin
      mismatched++;
      $error("FAIL data_const out_port observed=%h expected=%h", out_port, 8'h0F);
    end
    wr_reg(3'd3, 32'h0000_0030, "outset");
    wr_reg(3'd4, 32'h0000_0005, "outclear");
    compared++;
    assert (out_port === 8'h3A) else begin
      mismatched++;
      $error("FAIL setclr_const out_port observed=%h expected=%h", out_port, 8'h3A);
    end
    rd_reg(3'd0, "read_data");

    wr_reg(3'd2, 32'd4, "period4");
    wr_reg(3'd1, 32'h01, "blink_en");
    wr_reg(3'd0, 32'h03, "data3");
    idle(20, "blink4");
    wr_reg(3'd0, 32'h02, "clr_bit0");
    idle(10, "blink_zero");

    wr_reg(3'd0, 32'h03, "data3b");
    idle(5, "blink_mid");
    wr_reg(3'd2, 32'd2, "period2");
    idle(7, "blink2");
    wr_reg(3'd2, 32'd0, "period0");
    idle(6, "steady");

    for (int a = 5; a < 8; a++) wr_reg(3'(a), $urandom, "reserved_wr");
    wr_reg(3'd0, 32'hABCD_1200 | 32'h5A, "garbage_hi");
    wr_reg(3'd1, 32'hFFFF_FF00, "garbage_blink");
    for (int a = 4; a < 8; a++) rd_reg(3'(a), "reserved_rd");
    for (int a = 0; a < 4; a++) rd_reg(3'(a), "after_garbage");

    wr_reg(3'd0, 32'hFF, "data_ff");
    wr_reg(3'd1, 32'hF0, "blink_f0");
    wr_reg(3'd2, 32'd3, "period3");
    idle(4, "pre_reset");
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h12, "mid_reset");
    for (int a = 0; a < 4; a++) rd_reg(3'(a), "post_reset");

    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = {d[31:24], 21'd0, 3'($urandom_range(0, 6))};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0), a, d, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_pio_blink.md
Name: led_pio_blink

Overview:
- Parametrised Avalon-MM slave output port for LEDs and other static indicators.
- Successor to the fixed-width single-register output PIO: configurable channel count and reset value.
- Adds atomic set/clear write addresses and a per-channel hardware blink mode driven by a shared programmable prescaler.
- Sits on the system interconnect as an Avalon-MM slave, with out_port routed to board pins.

Parameters:
- WIDTH, 8, number of output channels (1..32).
- PRESCALE_WIDTH, 24, width of the blink half-period register and counter (1..32).
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits).
- RESET_PERIOD, 0, reset value of the PERIOD register.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  read data; combinational, read latency 0.
- out_port  output  WIDTH  registered channel outputs.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Only writedata[WIDTH-1:0] is used, except at address 2, which uses [PRESCALE_WIDTH-1:0].
- Register map:
  - 0 DATA: read/write; the commanded channel level.
  - 1 BLINK_EN: read/write mask; 1 = channel blinks.
  - 2 PERIOD: read/write; blink half-period in clk cycles.
  - 3 OUTSET: write: DATA <= DATA | wd. Read: current out_port.
  - 4 OUTCLEAR: write: DATA <= DATA & ~wd. Read: 0.
  - 5..7: reserved; writes ignored, reads 0.
- Readdata is zero-extended to 32 bits. It is valid in the same cycle as address/chipselect and reflects register state before any same-cycle write.
- Reset values (reset sampled high at a clk edge):
  - DATA = RESET_VALUE; BLINK_EN = 0; PERIOD = RESET_PERIOD.
  - cnt = 0; phase = 1.
  - out_port = RESET_VALUE[WIDTH-1:0] (reset loads the output register directly).
- Prescaler (cnt, PRESCALE_WIDTH bits):
  - PERIOD == 0: cnt held at 0 and phase held at 1, so blinking channels show DATA steadily.
  - PERIOD != 0: when cnt == PERIOD-1, set cnt <= 0 and toggle phase; otherwise cnt <= cnt+1.
  - Full phase cycle is 2*PERIOD clocks.
- Write to PERIOD (any value): in the same edge, cnt <= 0 and phase <= 1. The new period takes effect from the next cycle; there is no wrap-around artefact when the period is shortened.
- Output register, every cycle: out_port <= DATA_next & ~(BLINK_EN_next & {WIDTH{~phase_next}}).
  - "_next" means the value being loaded at this edge.
  - Result: a register write is visible on out_port exactly 1 cycle after the write edge; a phase toggle is also visible 1 cycle after it.
- A blinking channel whose DATA bit is 0 stays 0.
- Non-blinking channels ignore phase and are glitch-free.
- Writing BLINK_EN does not disturb cnt or phase. Newly enabled channels join the running phase immediately.
- Reset asserted mid-blink or mid-write overrides everything; the write is discarded.
- Only one access per cycle exists, so the OUTSET/OUTCLEAR/DATA write priority question does not arise.
- chipselect low or write_n high: no state change except the prescaler.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata@0=A5, @1=0, @2=0, @3=A5.
- Write DATA=8'h0F, then OUTSET 8'h30, then OUTCLEAR 8'h05 -> out_port=0F, 3F, 3A, each change 1 cycle after its write edge; read @0 = 8'h3A.
- PERIOD=4, BLINK_EN=8'h01, DATA=8'h03 -> bit0 toggles every 4 clocks (8-cycle period, high first after the PERIOD write), bit1 held at 1, and bit0 stays 0 once DATA bit0 is cleared.
- Mid-blink (phase=0), write PERIOD=2 -> out_port bit0 returns to 1 on the next cycle, then toggles every 2 clocks; write PERIOD=0 -> bit0 steady at 1.
- Writes to address 5..7 and writedata[31:WIDTH] garbage with WIDTH=8 -> no register change; reads @4..7 = 0.
- Assert reset for 1 cycle during active blinking with DATA=FF -> next cycle out_port=RESET_VALUE, BLINK_EN=0, PERIOD=RESET_PERIOD, phase=1.
